// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: requester owner ids, FSM states,
// and the registered bus command bundle.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_EXE   = 2'd2,
        OWN_DMA   = 2'd3
    } owner_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [15:0] BUS_IDLE_ADDR = 16'h0000;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw_n;
        logic [7:0]  wdata;
    } bus_cmd_t;

    localparam bus_cmd_t BUS_CMD_RESET = '{addr: BUS_IDLE_ADDR, rw_n: 1'b1, wdata: 8'h00};

endpackage

// File: rtl/bus_prio_sel.sv
// Fixed-priority winner selection (DMA > EXE > FETCH); a held execute lock
// restricts the candidates to EXE alone.
module bus_prio_sel
    import mem_bus_arbiter_pkg::*;
(
    input  logic   f_req_i,
    input  logic   exe_req_i,
    input  logic   dma_req_i,
    input  logic   lock_i,
    input  owner_e owner_i,
    output owner_e win_owner_o,
    output logic   win_vld_o
);

    always_comb begin
        win_owner_o = OWN_NONE;
        win_vld_o   = 1'b0;
        // Under lock nobody else may take the bus, even while EXE is quiet.
        if (lock_i && (owner_i == OWN_EXE)) begin
            if (exe_req_i) begin
                win_owner_o = OWN_EXE;
                win_vld_o   = 1'b1;
            end
        end else if (dma_req_i) begin
            win_owner_o = OWN_DMA;
            win_vld_o   = 1'b1;
        end else if (exe_req_i) begin
            win_owner_o = OWN_EXE;
            win_vld_o   = 1'b1;
        end else if (f_req_i) begin
            win_owner_o = OWN_FETCH;
            win_vld_o   = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-owner arbiter for the CPU memory bus: one registered access per cycle,
// read data captured at the end of the granted cycle and acked the cycle after.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_gnt,
    output logic        f_ack,
    input  logic        exe_req,
    input  logic        exe_lock,
    input  logic [15:0] exe_addr,
    input  logic        exe_rw_n,
    input  logic [7:0]  exe_wdata,
    output logic        exe_gnt,
    output logic        exe_ack,
    input  logic        dma_req,
    input  logic        dma_rw_n,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [7:0]  rd_data,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] addr_bus,
    output logic [7:0]  mem_data_out,
    output logic        rw_n,
    output logic        memory_access,
    output logic        cpu_halt
);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    owner_e     win_owner;
    logic       win_vld;
    logic       lock_q, lock_d, lock_active;
    bus_cmd_t   cmd_q, cmd_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [2:0] ack_q, ack_d;
    logic [2:0] gnt;
    logic       halt_q, halt_d;
    logic       access;

    assign lock_active = lock_q & exe_lock;

    bus_prio_sel u_prio_sel (
        .f_req_i     (f_req),
        .exe_req_i   (exe_req),
        .dma_req_i   (dma_req),
        .lock_i      (lock_active),
        .owner_i     (owner_q),
        .win_owner_o (win_owner),
        .win_vld_o   (win_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every access is single-cycle, so arbitration re-runs at every edge.
    always_comb begin
        state_d = win_vld ? ST_ACCESS : ST_IDLE;
    end

    always_comb begin
        access        = (state_q == ST_ACCESS);
        gnt[0]        = access && (owner_q == OWN_FETCH);
        gnt[1]        = access && (owner_q == OWN_EXE);
        gnt[2]        = access && (owner_q == OWN_DMA);
        f_gnt         = gnt[0];
        exe_gnt       = gnt[1];
        dma_gnt       = gnt[2];
        f_ack         = ack_q[0];
        exe_ack       = ack_q[1];
        dma_ack       = ack_q[2];
        memory_access = access;
        addr_bus      = cmd_q.addr;
        rw_n          = cmd_q.rw_n;
        mem_data_out  = cmd_q.wdata;
        rd_data       = rd_data_q;
        cpu_halt      = halt_q;
    end

    always_comb begin
        cmd_d = cmd_q;
        if (win_vld) begin
            case (win_owner)
                OWN_FETCH: begin
                    cmd_d.addr = f_addr;
                    cmd_d.rw_n = 1'b1;
                end
                OWN_EXE:   cmd_d = '{addr: exe_addr, rw_n: exe_rw_n, wdata: exe_wdata};
                OWN_DMA:   cmd_d = '{addr: dma_addr, rw_n: dma_rw_n, wdata: dma_wdata};
                default:   cmd_d = cmd_q;
            endcase
        end

        // Lock is taken by an EXE grant with exe_lock high and survives idle cycles.
        lock_d    = exe_lock & (lock_q | (win_vld & (win_owner == OWN_EXE)));
        owner_d   = win_vld ? win_owner : (lock_d ? OWN_EXE : OWN_NONE);
        rd_data_d = (access && cmd_q.rw_n) ? mem_data_in : rd_data_q;
        ack_d     = gnt;
        halt_d    = dma_req | (access & (owner_q == OWN_DMA));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q   <= OWN_NONE;
            lock_q    <= 1'b0;
            cmd_q     <= BUS_CMD_RESET;
            rd_data_q <= 8'h00;
            ack_q     <= 3'b000;
            halt_q    <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            lock_q    <= lock_d;
            cmd_q     <= cmd_d;
            rd_data_q <= rd_data_d;
            ack_q     <= ack_d;
            halt_q    <= halt_d;
        end
    end

endmodule
